// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: queue entry layout, FSM states, PC increment.
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  typedef enum logic {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fq_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue_storage.sv
// Circular buffer of fetched words; flush wins over same-cycle push and pop.
module fetch_queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupled fetch front end: credit-limited imem reads, response queue, redirect with stale-response drain.
// Optional zero-latency empty-queue bypass under FETCH_QUEUE_BYPASS_EN.
module instruction_fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcadd4,
  output logic [31:0] out_pcadd8,
  output logic [31:0] out_pcsub4
);
  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   MAX_OS_C = CW'(MAX_OUTSTANDING);

  fq_state_t      state;
  logic [31:0]    fetch_pc, resp_pc;
  logic [CW-1:0]  outstanding, drop_cnt, drop_next, count;
  logic [CW:0]    inflight;
  logic           run, accept, resp_live, bypass_hit, push, pop, empty;
  fq_entry_t      stored, in_entry, head;

  assign run      = (state == FQ_RUN);
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign imem_req = ~reset & run & ~redirect & (inflight < DEPTH_C) & (outstanding < MAX_OS_C);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req & ~imem_busy;

  // Responses are in order, so the tag is just the PC of the oldest unanswered read.
  assign resp_live = imem_rvalid & run & ~redirect & ~reset;
  assign in_entry  = '{instr: imem_rdata, pc: resp_pc};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = empty & resp_live;
  assign head       = empty ? in_entry : stored;
`else
  assign bypass_hit = 1'b0;
  assign head       = stored;
`endif

  assign out_valid = ~reset & ~redirect & (~empty | bypass_hit);
  assign pop       = out_valid & out_ready & ~empty;
  assign push      = resp_live & ~(bypass_hit & out_ready);

  assign out_instr  = out_valid ? head.instr : '0;
  assign out_pc     = out_valid ? head.pc : '0;
  assign out_pcadd4 = out_valid ? head.pc + PC_STEP : '0;
  assign out_pcadd8 = out_valid ? head.pc + (PC_STEP << 1) : '0;
  assign out_pcsub4 = out_valid ? head.pc - PC_STEP : '0;

  // In DRAIN no reads are issued, so drop_cnt alone tracks what is still in flight.
  assign drop_next = (run ? outstanding : drop_cnt) - CW'(imem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FQ_RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (accept || (imem_rvalid && outstanding != '0))
        outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid && outstanding != '0);
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        resp_pc  <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= drop_next;
        state    <= (drop_next != '0) ? FQ_DRAIN : FQ_RUN;
      end else begin
        if (accept)    fetch_pc <= fetch_pc + PC_STEP;
        if (resp_live) resp_pc  <= resp_pc + PC_STEP;
        if (!run && imem_rvalid) begin
          drop_cnt <= drop_next;
          if (drop_next == '0) state <= FQ_RUN;
        end
      end
    end
  end

  fetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (in_entry),
    .pop       (pop),
    .head      (stored),
    .count     (count),
    .empty     (empty)
  );

endmodule
